// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA frame-buffer access path.
// Contents:
//   - 1024x768 @ 65 MHz timing constants (sync / back porch / active / front)
//   - first and last-plus-one active counter values
//   - frame-buffer geometry (128x96 words, 8x upscale)
//   - writer FSM state encoding
//   - range check helper for writer addresses
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [10:0] H_SYNC      = 11'd136;
    localparam logic [10:0] H_BACK      = 11'd160;
    localparam logic [10:0] H_ACTIVE    = 11'd1024;
    localparam logic [10:0] H_FRONT     = 11'd24;
    localparam logic [10:0] H_TOTAL     = 11'd1344;
    localparam logic [10:0] H_ACT_START = 11'd296;
    localparam logic [10:0] H_ACT_END   = 11'd1320;

    // Vertical timing, in lines
    localparam logic [9:0]  V_SYNC      = 10'd6;
    localparam logic [9:0]  V_BACK      = 10'd29;
    localparam logic [9:0]  V_ACTIVE    = 10'd768;
    localparam logic [9:0]  V_FRONT     = 10'd3;
    localparam logic [9:0]  V_TOTAL     = 10'd806;
    localparam logic [9:0]  V_ACT_START = 10'd35;
    localparam logic [9:0]  V_ACT_END   = 10'd803;

    // Frame-buffer geometry: each stored word covers an 8x8 screen block
    localparam logic [7:0]  FB_COLS     = 8'd128;
    localparam logic [6:0]  FB_ROWS     = 7'd96;
    localparam logic [13:0] FB_WORDS    = 14'd12288;
    localparam int unsigned SCALE_LOG2  = 32'd3;

    // Writer handshake FSM
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_WRITE   = 2'd1,
        WR_RELEASE = 2'd2
    } wr_state_e;

    // True when a writer address lands inside the populated frame buffer
    function automatic logic fb_in_range(input logic [13:0] addr);
        return (addr < FB_WORDS);
    endfunction

endpackage

// File: rtl/vga_delaymod.sv
// vga_delaymod: N-stage register pipe used to align control flags with the
// memory read latency.
// Ports:
//   CLOCK  in   pixel clock
//   RESET  in   asynchronous active-low reset, clears every stage to 0
//   iD     in   W-bit input
//   oQ     out  iD delayed by N clocks
module vga_delaymod #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 1
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [W-1:0] iD,
    output logic [W-1:0] oQ
);

    logic [W-1:0] pipe_r [N];

    // Shift register chain, stage 0 takes the input
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(N); i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= iD;
            for (int i = 1; i < int'(N); i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign oQ = pipe_r[N-1];

endmodule

// File: rtl/vga_ctrlmod.sv
// vga_ctrlmod: frame-buffer access controller between the VGA timing
// generator and a single-port 128x96x16 pixel memory.
// Ports:
//   CLOCK, RESET       pixel clock, async active-low reset
//   iAddr              {X[10:0], Y[9:0]} raw timing counters
//   iWr_Req/Addr/Data  writer level request, word address, RGB565 data
//   oWr_Done           one-cycle pulse when the writer request is serviced
//   oMem_Addr/We/WData registered memory port
//   iMem_RData         memory read data, valid 1 clock after oMem_Addr
//   oRGB               pixel data aligned to 3-clock-delayed syncs
//   oFrame_Start       pulse aligned to pixel (0,0) at the output
module vga_ctrlmod
    import vga_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [20:0] iAddr,
    input  logic        iWr_Req,
    input  logic [13:0] iWr_Addr,
    input  logic [15:0] iWr_Data,
    output logic        oWr_Done,
    output logic [13:0] oMem_Addr,
    output logic        oMem_We,
    output logic [15:0] oMem_WData,
    input  logic [15:0] iMem_RData,
    output logic [15:0] oRGB,
    output logic        oFrame_Start
);

    logic [10:0] x_s;
    logic [9:0]  y_s;
    logic [9:0]  xa_s;
    logic [6:0]  ya_row_s;
    logic        active_s;
    logic        fetch_s;
    logic        frame_s;
    logic [13:0] fetch_addr_s;

    wr_state_e   state_r;
    wr_state_e   state_s;

    logic [13:0] mem_addr_s;
    logic        mem_we_s;
    logic [15:0] mem_wdata_s;
    logic        wr_done_s;

    logic [13:0] mem_addr_r;
    logic        mem_we_r;
    logic [15:0] mem_wdata_r;
    logic        wr_done_r;
    logic        fetch_d1_r;
    logic        fetch_d2_r;
    logic [15:0] pixel_r;
    logic        active_d3_s;
    logic        frame_d3_s;

    assign x_s = iAddr[20:10];
    assign y_s = iAddr[9:0];

    // xa only matters inside the active window, where it never exceeds 1023
    assign xa_s     = 10'(x_s - H_ACT_START);
    assign ya_row_s = 7'((y_s - V_ACT_START) >> SCALE_LOG2);

    assign active_s     = (x_s >= H_ACT_START) && (x_s < H_ACT_END) &&
                          (y_s >= V_ACT_START) && (y_s < V_ACT_END);
    // One fetch per 8-pixel block: the stored word is replicated 8x on screen
    assign fetch_s      = active_s && (xa_s[2:0] == 3'd0);
    assign fetch_addr_s = {ya_row_s, xa_s[9:3]};
    assign frame_s      = (iAddr == 21'd0);

    // Writer FSM state register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r <= WR_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Writer FSM next state; a fetch slot defers the grant by one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            WR_IDLE: begin
                if (iWr_Req && !fetch_s) begin
                    state_s = WR_WRITE;
                end else begin
                    state_s = WR_IDLE;
                end
            end
            WR_WRITE: begin
                state_s = WR_RELEASE;
            end
            WR_RELEASE: begin
                // The request must drop before it can be serviced again
                if (!iWr_Req) begin
                    state_s = WR_IDLE;
                end else begin
                    state_s = WR_RELEASE;
                end
            end
            default: begin
                state_s = WR_IDLE;
            end
        endcase
    end

    // Memory port next values: fetch has priority, writer is granted on entry to WRITE
    always_comb begin
        mem_addr_s  = mem_addr_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = mem_wdata_r;
        wr_done_s   = 1'b0;
        if (fetch_s) begin
            mem_addr_s = fetch_addr_s;
        end else if (state_s == WR_WRITE) begin
            mem_addr_s  = iWr_Addr;
            mem_wdata_s = iWr_Data;
            mem_we_s    = fb_in_range(iWr_Addr);
            wr_done_s   = 1'b1;
        end else begin
            mem_addr_s = mem_addr_r;
        end
    end

    // Registered memory port and writer handshake
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            mem_addr_r  <= 14'd0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 16'd0;
            wr_done_r   <= 1'b0;
        end else begin
            mem_addr_r  <= mem_addr_s;
            mem_we_r    <= mem_we_s;
            mem_wdata_r <= mem_wdata_s;
            wr_done_r   <= wr_done_s;
        end
    end

    // Track which memory cycles were display fetches, then capture their read data
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            fetch_d1_r <= 1'b0;
            fetch_d2_r <= 1'b0;
            pixel_r    <= 16'd0;
        end else begin
            fetch_d1_r <= fetch_s;
            fetch_d2_r <= fetch_d1_r;
            if (fetch_d2_r) begin
                pixel_r <= iMem_RData;
            end else begin
                pixel_r <= pixel_r;
            end
        end
    end

    vga_delaymod #(.N(3), .W(1)) u_active_dly (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .iD    (active_s),
        .oQ    (active_d3_s)
    );

    vga_delaymod #(.N(3), .W(1)) u_frame_dly (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .iD    (frame_s),
        .oQ    (frame_d3_s)
    );

    assign oMem_Addr    = mem_addr_r;
    assign oMem_We      = mem_we_r;
    assign oMem_WData   = mem_wdata_r;
    assign oWr_Done     = wr_done_r;
    assign oRGB         = active_d3_s ? pixel_r : 16'h0000;
    assign oFrame_Start = frame_d3_s;

endmodule

// File: tb/tb_vga_ctrlmod.sv
// tb_vga_ctrlmod: directed self-checking bench for vga_ctrlmod.
// The memory model returns read data equal to the registered address.
module tb_vga_ctrlmod;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [20:0] iAddr;
    logic        iWr_Req;
    logic [13:0] iWr_Addr;
    logic [15:0] iWr_Data;
    logic        oWr_Done;
    logic [13:0] oMem_Addr;
    logic        oMem_We;
    logic [15:0] oMem_WData;
    logic [15:0] iMem_RData;
    logic [15:0] oRGB;
    logic        oFrame_Start;

    int n_vec  = 0;
    int n_miss = 0;

    vga_ctrlmod dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .iAddr        (iAddr),
        .iWr_Req      (iWr_Req),
        .iWr_Addr     (iWr_Addr),
        .iWr_Data     (iWr_Data),
        .oWr_Done     (oWr_Done),
        .oMem_Addr    (oMem_Addr),
        .oMem_We      (oMem_We),
        .oMem_WData   (oMem_WData),
        .iMem_RData   (iMem_RData),
        .oRGB         (oRGB),
        .oFrame_Start (oFrame_Start)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous memory: data = address, one clock after the address
    always @(posedge CLOCK) begin
        iMem_RData <= {2'b00, oMem_Addr};
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive_xy(input int x, input int y);
        iAddr = {11'(x), 10'(y)};
    endtask

    function automatic bit is_fetch(input int x, input int y);
        return (x >= 296) && (x < 1320) && (y >= 35) && (y < 803) && (((x - 296) % 8) == 0);
    endfunction

    initial begin
        RESET      = 1'b0;
        iAddr      = 21'd0;
        iWr_Req    = 1'b0;
        iWr_Addr   = 14'd0;
        iWr_Data   = 16'd0;
        iMem_RData = 16'd0;
        tick();
        tick();

        // Reset state
        check_vec("rst_addr",  32'(oMem_Addr),    32'd0);
        check_vec("rst_we",    32'(oMem_We),      32'd0);
        check_vec("rst_wdata", 32'(oMem_WData),   32'd0);
        check_vec("rst_done",  32'(oWr_Done),     32'd0);
        check_vec("rst_rgb",   32'(oRGB),         32'd0);
        check_vec("rst_frame", 32'(oFrame_Start), 32'd0);

        // Frame start: iAddr = {0,0} shows up 3 edges later
        RESET = 1'b1;
        drive_xy(0, 0);
        tick();
        drive_xy(1, 0);
        check_vec("frame_e1", 32'(oFrame_Start), 32'd0);
        tick();
        check_vec("frame_e2", 32'(oFrame_Start), 32'd0);
        tick();
        check_vec("frame_e3", 32'(oFrame_Start), 32'd1);
        tick();
        check_vec("frame_e4", 32'(oFrame_Start), 32'd0);

        // Last active line: row 95 fetches, ending at word 12287, no writes
        for (int x = 0; x < 1344; x++) begin
            drive_xy(x, 802);
            tick();
            if (is_fetch(x, 802)) begin
                check_vec("line802_addr", 32'(oMem_Addr), 32'(95 * 128 + (x - 296) / 8));
            end
            if ((x % 64) == 0) begin
                check_vec("line802_we", 32'(oMem_We), 32'd0);
            end
            if ((x < 299) && ((x % 32) == 0)) begin
                check_vec("blank_rgb", 32'(oRGB), 32'd0);
            end
        end
        check_vec("last_fetch", 32'(oMem_Addr), 32'd12287);

        // First line after the active area: nothing fetched, address held
        for (int x = 296; x < 312; x++) begin
            drive_xy(x, 803);
            tick();
        end
        check_vec("vend_addr", 32'(oMem_Addr), 32'd12287);
        check_vec("vend_rgb",  32'(oRGB),      32'd0);

        // First active line: word 0 for 8 pixels, then word 1
        for (int x = 290; x < 296; x++) begin
            drive_xy(x, 35);
            tick();
        end
        for (int k = 0; k < 14; k++) begin
            drive_xy(296 + k, 35);
            tick();
            check_vec("row0_rgb", 32'(oRGB), (k + 1 >= 11) ? 32'h0001 : 32'h0000);
        end

        // Row 1 (Y=43): 0x0080 from the 3rd edge, 0x0081 from the 11th
        for (int x = 290; x < 296; x++) begin
            drive_xy(x, 43);
            tick();
        end
        for (int k = 0; k < 13; k++) begin
            drive_xy(296 + k, 43);
            tick();
            check_vec("row1_rgb", 32'(oRGB),
                      (k + 1 < 3) ? 32'h0000 : ((k + 1 < 11) ? 32'h0080 : 32'h0081));
        end

        // Right edge of row 1: last word 0x00FF, then blank once X reaches 1320
        for (int k = 0; k < 12; k++) begin
            drive_xy(1312 + k, 43);
            tick();
            if (k + 1 >= 3) begin
                check_vec("hend_rgb", 32'(oRGB), (k + 1 < 11) ? 32'h00FF : 32'h0000);
            end
        end

        // Writer in blanking: immediate grant, single done, held in RELEASE
        drive_xy(10, 10);
        iWr_Req  = 1'b1;
        iWr_Addr = 14'h0105;
        iWr_Data = 16'hF800;
        tick();
        check_vec("wr_we",    32'(oMem_We),    32'd1);
        check_vec("wr_addr",  32'(oMem_Addr),  32'h0105);
        check_vec("wr_data",  32'(oMem_WData), 32'hF800);
        check_vec("wr_done",  32'(oWr_Done),   32'd1);
        tick();
        check_vec("wr_done_pulse", 32'(oWr_Done),  32'd0);
        check_vec("wr_we_drop",    32'(oMem_We),   32'd0);
        check_vec("wr_addr_hold",  32'(oMem_Addr), 32'h0105);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_vec("wr_release_done", 32'(oWr_Done), 32'd0);
            check_vec("wr_release_we",   32'(oMem_We),  32'd0);
        end
        iWr_Req = 1'b0;
        tick();
        iWr_Req  = 1'b1;
        iWr_Addr = 14'h0106;
        tick();
        check_vec("wr2_done", 32'(oWr_Done),  32'd1);
        check_vec("wr2_addr", 32'(oMem_Addr), 32'h0106);
        iWr_Req = 1'b0;
        tick();
        tick();

        // Request landing on a fetch slot (xa=8): fetch first, write next cycle
        drive_xy(304, 35);
        iWr_Req  = 1'b1;
        iWr_Addr = 14'h0222;
        iWr_Data = 16'h1234;
        tick();
        check_vec("slot_fetch_addr", 32'(oMem_Addr), 32'd1);
        check_vec("slot_fetch_we",   32'(oMem_We),   32'd0);
        check_vec("slot_fetch_done", 32'(oWr_Done),  32'd0);
        drive_xy(305, 35);
        tick();
        check_vec("slot_wr_addr", 32'(oMem_Addr),  32'h0222);
        check_vec("slot_wr_we",   32'(oMem_We),    32'd1);
        check_vec("slot_wr_data", 32'(oMem_WData), 32'h1234);
        check_vec("slot_wr_done", 32'(oWr_Done),   32'd1);
        iWr_Req = 1'b0;
        drive_xy(10, 10);
        tick();
        tick();

        // Out-of-range writer address: done pulses, no write enable
        iWr_Req  = 1'b1;
        iWr_Addr = 14'd12288;
        iWr_Data = 16'hABCD;
        tick();
        check_vec("oor_done", 32'(oWr_Done), 32'd1);
        check_vec("oor_we",   32'(oMem_We),  32'd0);
        iWr_Req = 1'b0;
        tick();
        tick();

        // Reset asserted while WRITE is on the port
        iWr_Req  = 1'b1;
        iWr_Addr = 14'h0333;
        iWr_Data = 16'h5555;
        tick();
        check_vec("pre_rst_we", 32'(oMem_We), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check_vec("midrst_addr",  32'(oMem_Addr),  32'd0);
        check_vec("midrst_we",    32'(oMem_We),    32'd0);
        check_vec("midrst_wdata", 32'(oMem_WData), 32'd0);
        check_vec("midrst_done",  32'(oWr_Done),   32'd0);
        check_vec("midrst_rgb",   32'(oRGB),       32'd0);
        tick();
        RESET = 1'b1;
        tick();
        check_vec("post_rst_done", 32'(oWr_Done),   32'd1);
        check_vec("post_rst_we",   32'(oMem_We),    32'd1);
        check_vec("post_rst_addr", 32'(oMem_Addr),  32'h0333);
        check_vec("post_rst_data", 32'(oMem_WData), 32'h5555);
        iWr_Req = 1'b0;
        tick();
        check_vec("post_rst_pulse", 32'(oWr_Done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
